// File: rtl/sample_ram_arbiter.sv
// Arbitrates one single-port sample RAM between a buffered capture write stream
// and display reads; writes yield to reads until the buffer fills or ages out.
module sample_ram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [8:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       rd_req,
  input  logic [8:0] rd_addr,
  output logic       rd_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic [8:0] ram_addr,
  output logic       ram_we,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata,
  output logic [4:0] fifo_count,
  output logic       draining
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_DRAIN  = 1'b1
  } state_t;

  logic [1:0]    rst_sync_r;
  logic          rst_n_s;
  state_t        state_r;
  state_t        state_nx_s;
  logic [16:0]   fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [4:0]    count_r;
  logic [4:0]    count_nx_s;
  logic [7:0]    wait_r;
  logic          rd_valid_r;
  logic [7:0]    rd_hold_r;
  logic [16:0]   head_s;
  logic          fifo_empty_s;
  logic          drain_trig_s;
  logic          drain_mode_s;
  logic          rd_ready_s;
  logic          rd_accept_s;
  logic          push_s;
  logic          pop_s;
  logic [8:0]    ram_addr_s;
  logic          ram_we_s;
  logic [7:0]    ram_wdata_s;

  // Reset synchroniser: assertion is immediate, release waits for two clock edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // Mode selection, arbitration and RAM port muxing for the current cycle.
  always_comb begin
    fifo_empty_s = (count_r == 5'd0);
    head_s       = fifo_mem_r[rd_ptr_r];
    drain_trig_s = 1'b0;
    drain_mode_s = 1'b0;
    state_nx_s   = state_r;
    ram_addr_s   = 9'd0;
    ram_we_s     = 1'b0;
    ram_wdata_s  = 8'd0;

    // The drain decision is made combinationally so the triggering cycle already writes.
    if (!fifo_empty_s &&
        ((count_r == 5'(FIFO_DEPTH)) || (wait_r == 8'(MAX_WAIT)))) begin
      drain_trig_s = 1'b1;
    end else begin
      drain_trig_s = 1'b0;
    end

    case (state_r)
      ST_NORMAL: drain_mode_s = drain_trig_s;
      ST_DRAIN:  drain_mode_s = 1'b1;
      default:   drain_mode_s = 1'b1;
    endcase

    rd_ready_s  = rst_n_s & ~drain_mode_s;
    rd_accept_s = rd_req & rd_ready_s;
    pop_s       = rst_n_s & ~fifo_empty_s & ~rd_accept_s;
    push_s      = rst_n_s & wr_req;
    count_nx_s  = count_r + {4'd0, push_s} - {4'd0, pop_s};

    if (drain_mode_s && (count_nx_s != 5'd0)) begin
      state_nx_s = ST_DRAIN;
    end else begin
      state_nx_s = ST_NORMAL;
    end

    if (rd_accept_s) begin
      ram_addr_s  = rd_addr;
      ram_we_s    = 1'b0;
      ram_wdata_s = 8'd0;
    end else if (pop_s) begin
      ram_addr_s  = head_s[16:8];
      ram_we_s    = 1'b1;
      ram_wdata_s = head_s[7:0];
    end else begin
      ram_addr_s  = 9'd0;
      ram_we_s    = 1'b0;
      ram_wdata_s = 8'd0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r <= ST_NORMAL;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Write-buffer storage; contents are don't-care while the pointers mark it empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {wr_addr, wr_data};
    end
  end

  // Buffer pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= 5'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_nx_s;
    end
  end

  // Age of the head entry while reads keep it off the RAM port.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      wait_r <= 8'd0;
    end else if (fifo_empty_s || pop_s) begin
      wait_r <= 8'd0;
    end else if (wait_r != 8'hFF) begin
      wait_r <= wait_r + 8'd1;
    end
  end

  // Read response: valid one cycle after acceptance, data held between responses.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      rd_valid_r <= 1'b0;
      rd_hold_r  <= 8'd0;
    end else begin
      rd_valid_r <= rd_accept_s;
      if (rd_valid_r) begin
        rd_hold_r <= ram_rdata;
      end
    end
  end

  assign rd_ready   = rd_ready_s;
  assign rd_valid   = rd_valid_r;
  assign rd_data    = rd_valid_r ? ram_rdata : rd_hold_r;
  assign ram_addr   = ram_addr_s;
  assign ram_we     = ram_we_s;
  assign ram_wdata  = ram_wdata_s;
  assign fifo_count = count_r;
  assign draining   = drain_mode_s;

endmodule

// File: doc/sample_ram_arbiter.md
SAMPLE_RAM_ARBITER -- requirements
Module: sample_ram_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, write-buffer entries (power of 2, 2..16).
REQ-002 Parameter MAX_WAIT, default 8, max cycles a pending write may be denied before forced drain (1..255).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; 0 resets immediately, release synchronised to clk edge.
REQ-005 wr_req  in  1  capture write strobe; one sample per asserted cycle, no back-pressure.
REQ-006 wr_addr  in  9  {bank, index} write address.
REQ-007 wr_data  in  8  write sample.
REQ-008 rd_req  in  1  display read request.
REQ-009 rd_addr  in  9  display read address.
REQ-010 rd_ready  out  1  read accepted this cycle when rd_req & rd_ready.
REQ-011 rd_valid  out  1  pulses one cycle after an accepted read.
REQ-012 rd_data  out  8  read sample, qualified by rd_valid, held otherwise.
REQ-013 ram_addr  out  9  single-port RAM address.
REQ-014 ram_we  out  1  RAM write enable.
REQ-015 ram_wdata  out  8  RAM write data.
REQ-016 ram_rdata  in  8  RAM read data, valid one cycle after a read-addressed cycle.
REQ-017 fifo_count  out  5  current write-buffer occupancy.
REQ-018 draining  out  1  high while in DRAIN mode.

Function
REQ-019 Every wr_req cycle SHALL push {wr_addr, wr_data} into the write FIFO; no direct RAM bypass, minimum write latency 1 cycle.
REQ-020 Push into a full FIFO SHALL succeed only because a forced pop occurs the same cycle (REQ-024); no entry is ever lost.
REQ-021 FSM states NORMAL and DRAIN; reset state NORMAL.
REQ-022 NORMAL: rd_ready=1; if rd_req, RAM cycle = read (ram_addr=rd_addr, ram_we=0); else if FIFO non-empty, RAM cycle = write of FIFO head (pop).
REQ-023 NORMAL: wait counter (8 bit) increments each cycle FIFO non-empty and no pop, clears on any pop or when FIFO empty.
REQ-024 NORMAL->DRAIN when fifo_count==FIFO_DEPTH or wait counter==MAX_WAIT; transition evaluated combinationally so the triggering cycle already performs a write and rd_ready=0.
REQ-025 DRAIN: rd_ready=0, head written every cycle; DRAIN->NORMAL on the edge where post-update occupancy is 0.
REQ-026 Simultaneous push and pop SHALL leave fifo_count unchanged; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-027 No read-after-write forwarding: a read of an address still buffered returns old RAM contents.
REQ-028 rd_data SHALL capture ram_rdata on the cycle rd_valid=1; idle cycles: ram_addr=0, ram_we=0, ram_wdata=0.
REQ-029 At most one RAM access (read or write) per cycle; ram_we=1 never coincides with an accepted read.

Reset
REQ-030 While reset=0: state NORMAL, FIFO empty, fifo_count=0, wait counter=0, rd_valid=0, rd_data=0, draining=0, ram_we=0.
REQ-031 Reset mid-operation SHALL discard buffered writes and any in-flight read; no rd_valid follows a read accepted in the cycle reset asserts.

Verification
REQ-032 Write 0x5A to 0x013 with rd_req=0 -> next cycle ram_we=1, ram_addr=0x013, ram_wdata=0x5A, fifo_count back to 0.
REQ-033 Continuous rd_req, 3 writes queued -> reads served, after MAX_WAIT=8 denied cycles draining=1, rd_ready=0, 3 writes in order, then NORMAL.
REQ-034 Continuous rd_req and wr_req every cycle -> FIFO reaches 4, DRAIN entered, count never exceeds 4, no write lost, write order preserved.
REQ-035 Read 0x100 accepted at cycle N -> rd_valid=1 exactly cycle N+1, rd_data=RAM[0x100]; no rd_valid without accept.
REQ-036 Assert reset with 2 writes buffered and a read in flight -> all outputs at reset values, rd_valid stays 0, buffered writes never reach RAM.
